// File: rtl/dpram_arb_pkg.sv
// Shared constants, port selector type and hazard helper for the
// dual-port RAM arbiter.
package dpram_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

    // Two accesses to the same word clash unless both are reads.
    // Addresses are passed zero-extended so any AW up to 32 fits.
    function automatic logic addr_conflict(input logic [31:0] addr_x,
                                           input logic        we_x,
                                           input logic [31:0] addr_y,
                                           input logic        we_y);
        return (addr_x == addr_y) && (we_x || we_y);
    endfunction

endpackage

// File: rtl/dpram_arbiter_rr_pick.sv
// Rotating first-one finder: returns the first unmasked request found
// when scanning from start_i upward, wrapping modulo N.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  mask_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan all N positions; the first eligible hit wins.
    always_comb begin
        logic hit;
        int   pos;
        hit     = 1'b0;
        pos     = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!hit && req_i[pos] && !mask_i[pos]) begin
                hit   = 1'b1;
                idx_o = IW'(pos);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NREQ
// requesters, blocking same-address hazards and steering read data back.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic [AW-1:0]      ram_addr_a,
    output logic [AW-1:0]      ram_addr_b,
    output logic [DW-1:0]      ram_din_a,
    output logic [DW-1:0]      ram_din_b,
    output logic               ram_we_a,
    output logic               ram_we_b,
    output logic               ram_re_a,
    output logic               ram_re_b,
    input  logic [DW-1:0]      ram_dout_a,
    input  logic [DW-1:0]      ram_dout_b
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (int'(v) == NREQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    logic [IW-1:0]      ptr_q, ptr_d;
    logic               pend_a_q, pend_b_q;
    logic [IW-1:0]      id_a_q, id_b_q;
    logic [NREQ-1:0]    rvalid_q, rvalid_d;
    logic [NREQ*DW-1:0] rdata_q, rdata_d;

    logic [AW-1:0]      addr_arr [NREQ];
    logic [DW-1:0]      wdata_arr[NREQ];

    logic               a_found, b_found;
    logic [IW-1:0]      a_idx, b_idx, b_start;
    logic [NREQ-1:0]    b_mask;
    logic               grant_a, grant_b;
    logic [AW-1:0]      a_addr;
    logic               a_we;
    port_sel_t          last_port;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
            // Port B may not take A's requester nor anything that clashes with A.
            assign b_mask[gi] = (a_idx == IW'(gi))
                             || addr_conflict(32'(addr_arr[gi]), req_we[gi],
                                              32'(a_addr), a_we);
        end
    endgenerate

    assign a_addr  = addr_arr[a_idx];
    assign a_we    = req_we[a_idx];
    assign b_start = wrap_inc(a_idx);

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
        .req_i   (req),
        .start_i (ptr_q),
        .mask_i  ({NREQ{1'b0}}),
        .found_o (a_found),
        .idx_o   (a_idx)
    );

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
        .req_i   (req),
        .start_i (b_start),
        .mask_i  (b_mask),
        .found_o (b_found),
        .idx_o   (b_idx)
    );

    // Grants are suppressed combinationally while reset is held.
    assign grant_a = a_found & rst;
    assign grant_b = grant_a & b_found;

    // Per-requester grant vector, at most one bit per port.
    always_comb begin
        gnt = '0;
        if (grant_a) begin
            gnt[a_idx] = 1'b1;
        end
        if (grant_b) begin
            gnt[b_idx] = 1'b1;
        end
    end

    // RAM port drive from the picks; idle ports are parked at zero.
    always_comb begin
        ram_addr_a = '0;
        ram_din_a  = '0;
        ram_we_a   = 1'b0;
        ram_re_a   = 1'b0;
        ram_addr_b = '0;
        ram_din_b  = '0;
        ram_we_b   = 1'b0;
        ram_re_b   = 1'b0;
        if (grant_a) begin
            ram_addr_a = addr_arr[a_idx];
            ram_din_a  = wdata_arr[a_idx];
            ram_we_a   = req_we[a_idx];
            ram_re_a   = ~req_we[a_idx];
        end
        if (grant_b) begin
            ram_addr_b = addr_arr[b_idx];
            ram_din_b  = wdata_arr[b_idx];
            ram_we_b   = req_we[b_idx];
            ram_re_b   = ~req_we[b_idx];
        end
    end

    // Priority moves just past the last requester served this cycle.
    always_comb begin
        last_port = grant_b ? PORT_B : PORT_A;
        ptr_d     = ptr_q;
        if (grant_a) begin
            ptr_d = (last_port == PORT_B) ? wrap_inc(b_idx) : wrap_inc(a_idx);
        end
    end

    // Read return: RAM output of the previous cycle's reads goes to their issuers.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (pend_a_q) begin
            rvalid_d[id_a_q]             = 1'b1;
            rdata_d[id_a_q*DW +: DW]     = ram_dout_a;
        end
        if (pend_b_q) begin
            rvalid_d[id_b_q]             = 1'b1;
            rdata_d[id_b_q*DW +: DW]     = ram_dout_b;
        end
    end

    // State registers; reset drops in-flight reads and restarts priority at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            id_a_q   <= '0;
            id_b_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            pend_a_q <= grant_a & ~a_we;
            pend_b_q <= grant_b & ~req_we[b_idx];
            id_a_q   <= a_idx;
            id_b_q   <= b_idx;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural registered-read RAM.
module tb_dpram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic [3:0]  ram_addr_a, ram_addr_b;
    logic [7:0]  ram_din_a, ram_din_b;
    logic        ram_we_a, ram_we_b, ram_re_a, ram_re_b;
    logic [7:0]  ram_dout_a, ram_dout_b;

    logic [7:0]  mem [16];
    logic [7:0]  sb  [16];
    logic        load_mem;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dpram_arbiter #(.NREQ(4), .AW(4), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_re_a   (ram_re_a),
        .ram_re_b   (ram_re_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    function automatic logic [7:0] init_val(input int k);
        return (k == 7) ? 8'h3C : 8'(8'h10 + k);
    endfunction

    // 16x8 dual-port RAM with registered read outputs.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 16; k++) mem[k] <= init_val(k);
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        end
        if (ram_re_a) ram_dout_a <= mem[ram_addr_a];
        if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
        req[i]            = 1'b1;
        req_we[i]         = we;
        req_addr[i*4 +: 4]  = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic clr_req(input int i);
        req[i] = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) sb[k] = init_val(k);
        rst = 1'b0;
        load_mem = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i + 1), 8'h00);
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_strobes", {28'h0, ram_we_a, ram_we_b, ram_re_a, ram_re_b}, 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        repeat (2) tick;
        load_mem = 1'b0;
        check("rst_hold_gnt", 32'(gnt), 32'h0);
        check("rst_rdata", rdata, 32'h0);

        // Release: ptr=0, reads 1..4 all held.
        @(negedge clk); rst = 1'b1; #1;
        check("rr1_gnt", 32'(gnt), 32'h3);
        check("rr1_addr_a", 32'(ram_addr_a), 32'h1);
        check("rr1_addr_b", 32'(ram_addr_b), 32'h2);
        check("rr1_re", {30'h0, ram_re_a, ram_re_b}, 32'h3);
        tick;                                   // E1
        clr_req(0); clr_req(1); #1;
        check("rr2_gnt", 32'(gnt), 32'hC);
        check("rr2_addr_a", 32'(ram_addr_a), 32'h3);
        check("rr2_addr_b", 32'(ram_addr_b), 32'h4);
        check("rr1_rvalid_wait", 32'(rvalid), 32'h0);
        tick;                                   // E2
        check("rr1_rvalid", 32'(rvalid), 32'h3);
        check("rr1_rdata0", 32'(rdata[7:0]), 32'h11);
        check("rr1_rdata1", 32'(rdata[15:8]), 32'h12);
        clr_req(2); clr_req(3); #1;
        check("idle_gnt", 32'(gnt), 32'h0);
        tick;                                   // E3
        check("rr2_rvalid", 32'(rvalid), 32'hC);
        check("rr2_rdata2", 32'(rdata[23:16]), 32'h13);
        check("rr2_rdata3", 32'(rdata[31:24]), 32'h14);

        // Write-write conflict at address 5, ptr=0.
        set_req(0, 1'b1, 4'h5, 8'hAA);
        set_req(1, 1'b1, 4'h5, 8'h55);
        #1;
        check("ww1_gnt", 32'(gnt), 32'h1);
        check("ww1_port_a", {20'h0, ram_we_a, ram_addr_a, ram_din_a}, {20'h0, 1'b1, 4'h5, 8'hAA});
        check("ww1_port_b", {30'h0, ram_we_b, ram_re_b}, 32'h0);
        sb[5] = 8'hAA;
        tick;                                   // E4
        check("ww_rvalid", 32'(rvalid), 32'h0);
        clr_req(0); #1;
        check("ww2_gnt", 32'(gnt), 32'h2);
        check("ww2_din_a", 32'(ram_din_a), 32'h55);
        sb[5] = 8'h55;
        tick;                                   // E5
        clr_req(1);
        check("ww_mem5", 32'(mem[5]), 32'h55);

        // Two reads of address 7, ptr=2.
        set_req(2, 1'b0, 4'h7, 8'h00);
        set_req(3, 1'b0, 4'h7, 8'h00);
        #1;
        check("rd7_gnt", 32'(gnt), 32'hC);
        check("rd7_addrs", {24'h0, ram_addr_a, ram_addr_b}, 32'h77);
        tick;                                   // E6
        clr_req(2); clr_req(3);
        tick;                                   // E7
        check("rd7_rvalid", 32'(rvalid), 32'hC);
        check("rd7_rdata2", 32'(rdata[23:16]), 32'h3C);
        check("rd7_rdata3", 32'(rdata[31:24]), 32'h3C);

        // Write then read across cycles, ptr=0.
        set_req(0, 1'b1, 4'hA, 8'h9F); #1;
        check("wr_a_gnt", 32'(gnt), 32'h1);
        sb[10] = 8'h9F;
        tick;                                   // E8
        clr_req(0);
        set_req(1, 1'b0, 4'hA, 8'h00); #1;
        check("rd_a_gnt", 32'(gnt), 32'h2);
        tick;                                   // E9
        clr_req(1);
        // Same pair in one cycle, ptr=2: read must wait behind the write.
        set_req(0, 1'b1, 4'hA, 8'h6E);
        set_req(1, 1'b0, 4'hA, 8'h00);
        #1;
        check("wr_rd_same_gnt", 32'(gnt), 32'h1);
        check("wr_rd_same_re_b", 32'(ram_re_b), 32'h0);
        sb[10] = 8'h6E;
        tick;                                   // E10
        check("rd_a_rvalid", 32'(rvalid), 32'h2);
        check("rd_a_rdata1", 32'(rdata[15:8]), 32'h9F);
        clr_req(0); #1;
        check("deferred_gnt", 32'(gnt), 32'h2);
        tick;                                   // E11
        clr_req(1);
        // ptr=2: requester 3 outranks requester 1.
        set_req(1, 1'b0, 4'h2, 8'h00);
        set_req(3, 1'b0, 4'h3, 8'h00);
        #1;
        check("prio_gnt", 32'(gnt), 32'hA);
        check("prio_addrs", {24'h0, ram_addr_a, ram_addr_b}, 32'h32);
        tick;                                   // E12
        check("deferred_rvalid", 32'(rvalid), 32'h2);
        check("deferred_rdata1", 32'(rdata[15:8]), 32'h6E);
        clr_req(1); clr_req(3);
        tick;                                   // E13
        check("prio_rvalid", 32'(rvalid), 32'hA);
        check("prio_rdata", {16'h0, rdata[31:24], rdata[15:8]}, 32'h1312);

        // Reset in the middle of a read.
        set_req(2, 1'b0, 4'h4, 8'h00); #1;
        check("mid_gnt", 32'(gnt), 32'h4);
        tick;                                   // E14, ptr becomes 3
        clr_req(2);
        #2 rst = 1'b0; #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'h0);
        repeat (2) tick;
        check("mid_rst_hold_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk); rst = 1'b1;
        tick;
        check("post_rst_rvalid", 32'(rvalid), 32'h0);
        set_req(0, 1'b0, 4'h1, 8'h00);
        set_req(3, 1'b0, 4'h4, 8'h00);
        #1;
        check("post_rst_gnt", 32'(gnt), 32'h9);
        check("post_rst_ptr_addr_a", 32'(ram_addr_a), 32'h1);
        tick;
        clr_req(0); clr_req(3);
        check("post_rst_rvalid_wait", 32'(rvalid), 32'h0);
        tick;
        check("post_rst_rvalid2", 32'(rvalid), 32'h9);
        check("post_rst_rdata", {16'h0, rdata[31:24], rdata[7:0]}, 32'h1411);

        // Every write the arbiter let through must have landed.
        for (int k = 0; k < 16; k++) begin
            check($sformatf("mem[%0d]", k), 32'(mem[k]), 32'(sb[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
